// File: rtl/viterbi_k3_decoder.sv
// viterbi_k3_decoder
//   Hard-decision Viterbi decoder for the rate-1/2, K=3, (5,7) convolutional code.
//   The encoder emits y[1] = u ^ s[0], y[0] = u ^ s[1] ^ s[0] and then moves to state {u, s[1]}.
//   The decoder runs a 4-state add-compare-select each accepted symbol and keeps
//   register-exchange survivors. Each accepted symbol yields at most one decoded bit.
//
// Parameters
//   TB_DEPTH  survivor length in symbols, which is also the decode latency (4..31)
//   PM_W      saturating path-metric width per state
//
// Ports
//   phi1             clock, rising edge
//   rst_n            asynchronous active-low reset
//   sync_s1          with in_valid_s1: this symbol starts a new frame
//   in_valid_s1      y_s1 carries a symbol this cycle
//   y_s1             received symbol {y2,y1}
//   self_test_s1     use the internal PRBS/encoder source (SELF_TEST_EN builds only)
//   data_valid_s1    one-cycle pulse, decoded_bit_s1 is valid
//   decoded_bit_s1   decoded information bit
//   decisions_s1     ACS decision per state for the last accepted symbol
//   path_metrics_s1  {pm3,pm2,pm1,pm0} after normalisation
//   orig_del_bit_s1  self-test source bit aligned with decoded_bit_s1
//   fail_s1          self-test mismatch between decoded_bit_s1 and orig_del_bit_s1
//
// Build option
//   SELF_TEST_EN  adds an internal 8-bit PRBS feeding a (5,7) encoder as an
//                 alternative symbol source, plus a delayed copy of the source
//                 bits for on-chip comparison. Without it, self_test_s1 is
//                 ignored and orig_del_bit_s1/fail_s1 are tied to 0.

module viterbi_k3_decoder #(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 4
) (
  input  logic                phi1,
  input  logic                rst_n,
  input  logic                sync_s1,
  input  logic                in_valid_s1,
  input  logic [1:0]          y_s1,
  input  logic                self_test_s1,
  output logic                data_valid_s1,
  output logic                decoded_bit_s1,
  output logic [3:0]          decisions_s1,
  output logic [4*PM_W-1:0]   path_metrics_s1,
  output logic                orig_del_bit_s1,
  output logic                fail_s1
);

  localparam int                FILL_W    = $clog2(TB_DEPTH + 1);
  localparam int                SV_W      = TB_DEPTH - 1;
  localparam logic [PM_W-1:0]   PM_MAX    = {PM_W{1'b1}};
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TB_DEPTH);

  function automatic logic [1:0] branch_metric(input logic [1:0] y, input logic [1:0] e);
    logic [1:0] diff;
    diff = y ^ e;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
    logic [PM_W:0] sum;
    sum = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
    return (sum > {1'b0, PM_MAX}) ? PM_MAX : sum[PM_W-1:0];
  endfunction

  logic                      accept;
  logic [1:0]                y_eff;
  logic [1:0]                st;
  logic [3:0][PM_W-1:0]      pm_q, pm_d, pm_base, cand0, cand1, pm_new, pm_norm;
  logic [3:0][SV_W-1:0]      surv_q, surv_d, surv_base;
  logic [3:0][TB_DEPTH-1:0]  surv_full;
  logic [3:0]                dec_new;
  logic [PM_W-1:0]           pm_min;
  logic [1:0]                best;
  logic                      dec_bit;
  logic                      valid_new;
  logic [FILL_W-1:0]         fill_q, fill_d, fill_base, fill_new;
  logic                      active_q, active_d;
  logic                      data_valid_q, data_valid_d;
  logic                      decoded_bit_q, decoded_bit_d;
  logic [3:0]                decisions_q, decisions_d;
  logic [4*PM_W-1:0]         path_metrics_q, path_metrics_d;

  // Add-compare-select, normalisation and survivor exchange for one symbol.
  // A sync symbol starts from the reset metrics/survivors instead of the stored ones,
  // which discards any undelivered tail of the previous frame.
  // Symbols are only accepted once a sync has opened a frame since reset.
  always_comb begin
    accept    = in_valid_s1 & (sync_s1 | active_q);
    pm_base   = sync_s1 ? {PM_MAX, PM_MAX, PM_MAX, {PM_W{1'b0}}} : pm_q;
    surv_base = sync_s1 ? '0 : surv_q;
    fill_base = sync_s1 ? '0 : fill_q;
    st        = 2'b00;
    cand0     = '0;
    cand1     = '0;
    pm_new    = '0;
    dec_new   = '0;
    surv_full = '0;
    pm_norm   = '0;
    for (int s = 0; s < 4; s++) begin
      st = 2'(s);
      // Predecessor {st[0],d}; input bit u = st[1]; branch symbol {u^d, u^st[0]^d}.
      cand0[s] = sat_add(pm_base[{st[0], 1'b0}],
                         branch_metric(y_eff, {st[1], st[1] ^ st[0]}));
      cand1[s] = sat_add(pm_base[{st[0], 1'b1}],
                         branch_metric(y_eff, {~st[1], ~(st[1] ^ st[0])}));
      dec_new[s] = (cand1[s] < cand0[s]);
      pm_new[s]  = dec_new[s] ? cand1[s] : cand0[s];
      surv_full[s] = dec_new[s] ? {surv_base[{st[0], 1'b1}], st[1]}
                                : {surv_base[{st[0], 1'b0}], st[1]};
    end
    // Strict compare keeps the lowest index on ties.
    pm_min = pm_new[0];
    best   = 2'd0;
    for (int s = 1; s < 4; s++) begin
      if (pm_new[s] < pm_min) begin
        pm_min = pm_new[s];
        best   = 2'(s);
      end
    end
    for (int s = 0; s < 4; s++) begin
      pm_norm[s] = pm_new[s] - pm_min;
    end
    dec_bit   = surv_full[best][TB_DEPTH-1];
    fill_new  = (fill_base == FILL_FULL) ? fill_base : fill_base + FILL_W'(1);
    valid_new = accept & (fill_new == FILL_FULL);

    pm_d     = accept ? pm_norm : pm_q;
    fill_d   = accept ? fill_new : fill_q;
    active_d = active_q | (in_valid_s1 & sync_s1);
    surv_d   = surv_q;
    for (int s = 0; s < 4; s++) begin
      if (accept) begin
        surv_d[s] = surv_full[s][SV_W-1:0];
      end
    end
    data_valid_d   = valid_new;
    decoded_bit_d  = accept ? dec_bit : decoded_bit_q;
    decisions_d    = accept ? dec_new : decisions_q;
    path_metrics_d = accept ? pm_norm : path_metrics_q;
  end

  // Decoder state and registered outputs.
  always_ff @(posedge phi1 or negedge rst_n) begin
    if (!rst_n) begin
      pm_q           <= {PM_MAX, PM_MAX, PM_MAX, {PM_W{1'b0}}};
      surv_q         <= '0;
      fill_q         <= '0;
      active_q       <= 1'b0;
      data_valid_q   <= 1'b0;
      decoded_bit_q  <= 1'b0;
      decisions_q    <= '0;
      path_metrics_q <= '0;
    end else begin
      pm_q           <= pm_d;
      surv_q         <= surv_d;
      fill_q         <= fill_d;
      active_q       <= active_d;
      data_valid_q   <= data_valid_d;
      decoded_bit_q  <= decoded_bit_d;
      decisions_q    <= decisions_d;
      path_metrics_q <= path_metrics_d;
    end
  end

  assign data_valid_s1   = data_valid_q;
  assign decoded_bit_s1  = decoded_bit_q;
  assign decisions_s1    = decisions_q;
  assign path_metrics_s1 = path_metrics_q;

`ifdef SELF_TEST_EN
  logic [7:0]          prbs_q, prbs_d, prbs_base;
  logic [1:0]          enc_q, enc_d, enc_base;
  logic [SV_W-1:0]     src_q, src_d, src_base;
  logic [TB_DEPTH-1:0] src_full;
  logic                st_q, st_d, st_eff, src_bit;
  logic                orig_q, orig_d, fail_q, fail_d;

  // Internal source: PRBS bit -> (5,7) encoder, plus a source-bit delay line
  // indexed exactly like the survivors so it lines up with the decoded bit.
  always_comb begin
    prbs_base = sync_s1 ? 8'h01 : prbs_q;
    enc_base  = sync_s1 ? 2'b00 : enc_q;
    src_base  = sync_s1 ? '0 : src_q;
    st_eff    = sync_s1 ? self_test_s1 : st_q;
    src_bit   = prbs_base[7];
    src_full  = {src_base, src_bit};
    y_eff     = st_eff ? {src_bit ^ enc_base[0], src_bit ^ enc_base[1] ^ enc_base[0]} : y_s1;
    prbs_d    = accept ? {prbs_base[6:1], prbs_base[7] ^ prbs_base[0], prbs_base[7]} : prbs_q;
    enc_d     = accept ? {src_bit, enc_base[1]} : enc_q;
    src_d     = accept ? src_full[SV_W-1:0] : src_q;
    st_d      = (accept & sync_s1) ? self_test_s1 : st_q;
  end

  assign orig_d = accept ? (st_eff & src_full[TB_DEPTH-1]) : orig_q;
  assign fail_d = valid_new & st_eff & (dec_bit ^ src_full[TB_DEPTH-1]);

  // Self-test state; the mode is latched on the sync cycle and held for the frame.
  always_ff @(posedge phi1 or negedge rst_n) begin
    if (!rst_n) begin
      prbs_q <= 8'h01;
      enc_q  <= 2'b00;
      src_q  <= '0;
      st_q   <= 1'b0;
      orig_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      prbs_q <= prbs_d;
      enc_q  <= enc_d;
      src_q  <= src_d;
      st_q   <= st_d;
      orig_q <= orig_d;
      fail_q <= fail_d;
    end
  end

  assign orig_del_bit_s1 = orig_q;
  assign fail_s1         = fail_q;
`else
  logic unused_self_test;

  assign y_eff            = y_s1;
  assign unused_self_test = self_test_s1;
  assign orig_del_bit_s1  = 1'b0;
  assign fail_s1          = 1'b0;
`endif

endmodule
